// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS main controller FSM with memory-ready handshake
module multicycle_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            iord,
    output logic            we_ir,
    output logic            we_dm,
    output logic            reg_dst,
    output logic            mem2reg,
    output logic            we_reg,
    output logic            jal,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
    localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
    localparam logic [ST_W-1:0] S_MEMADR = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEMRD  = ST_W'(3);
    localparam logic [ST_W-1:0] S_MEMWB  = ST_W'(4);
    localparam logic [ST_W-1:0] S_MEMWR  = ST_W'(5);
    localparam logic [ST_W-1:0] S_RTEX   = ST_W'(6);
    localparam logic [ST_W-1:0] S_RTWB   = ST_W'(7);
    localparam logic [ST_W-1:0] S_BEQEX  = ST_W'(8);
    localparam logic [ST_W-1:0] S_ADDIEX = ST_W'(9);
    localparam logic [ST_W-1:0] S_ADDIWB = ST_W'(10);
    localparam logic [ST_W-1:0] S_JEX    = ST_W'(11);
    localparam logic [ST_W-1:0] S_JALEX  = ST_W'(12);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign state = state_q;

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_RTEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_J:         state_nxt = S_JEX;
                    OP_JAL:       state_nxt = S_JALEX;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   state_nxt = S_RTWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Every output is a pure decode of the state; reset masks all of them.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        we_ir      = 1'b0;
        we_dm      = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        we_reg     = 1'b0;
        jal        = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    alu_src_b = 2'b01;
                    we_ir     = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_JAL, OP_LW, OP_SW: ;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    mem2reg    = 1'b1;
                    we_reg     = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    we_dm      = 1'b1;
                    instr_done = mem_ready;
                end
                S_RTEX: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RTWB: begin
                    reg_dst    = 1'b1;
                    we_reg     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQEX: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 2'b01;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    we_reg     = 1'b1;
                    instr_done = 1'b1;
                end
                S_JEX: begin
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                S_JALEX: begin
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                    we_reg     = 1'b1;
                    jal        = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle main controller for the MIPS core.
- Sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback states.
- Replaces the single-cycle decoder with a registered FSM and adds a memory-ready handshake.
- Supports R-type, ADDI, BEQ, J, JAL, LW and SW.

Parameters:
- ST_W, 4, state register width (13 states used).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- opcode  input  6  instr[31:26] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- pc_en  output  1  PC write enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- we_ir  output  1  instruction register write enable
- we_dm  output  1  memory write enable
- reg_dst  output  1  register write address: 0=rt, 1=rd
- mem2reg  output  1  register write data: 0=ALUOut, 1=MDR
- we_reg  output  1  register file write enable
- jal  output  1  force write address 31 and write data PC (already PC+4)
- alu_src_a  output  1  ALU A input: 0=PC, 1=rs
- alu_src_b  output  2  ALU B input: 00=rt, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2
- alu_op  output  2  to the ALU decoder: 00=add, 01=sub, 10=funct
- pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state  output  ST_W  current state, for debug and verification

Behaviour:
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, JALEX=12. Codes 13-15 are illegal and return to FETCH on the next clock.
- Reset: rst high forces state=FETCH asynchronously.
- While rst is high, force pc_en, we_ir, we_dm, we_reg, jal, instr_done and illegal_op to 0.
- While rst is high, force every other output to 0.
- Outputs are combinational decodes of state, plus zero and mem_ready where listed. Any signal not listed for a state is 0.
- FETCH:
  - alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, iord=0.
  - we_ir=mem_ready and pc_en=mem_ready.
  - Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target latched into ALUOut).
  - Next state: 000000 -> RTEX, 001000 -> ADDIEX, 000100 -> BEQEX, 000010 -> JEX, 000011 -> JALEX, 100011 or 101011 -> MEMADR.
  - Any other opcode: illegal_op=1, instr_done=1, next state FETCH (treated as NOP).
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_dst=0, mem2reg=1, we_reg=1, instr_done=1. Go to FETCH.
- MEMWR:
  - iord=1, we_dm=1; we_dm stays asserted while waiting.
  - instr_done=mem_ready.
  - Go to FETCH when mem_ready=1.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RTWB.
- RTWB: reg_dst=1, mem2reg=0, we_reg=1, instr_done=1. Go to FETCH.
- BEQEX:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en=zero, instr_done=1.
  - Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_dst=0, mem2reg=0, we_reg=1, instr_done=1. Go to FETCH.
- JEX: pc_src=10, pc_en=1, instr_done=1. Go to FETCH.
- JALEX:
  - pc_src=10, pc_en=1, we_reg=1, jal=1, instr_done=1.
  - The register write uses the pre-update PC (PC+4). Go to FETCH.
- Latency in cycles, with mem_ready=1 throughout:
  - R-type 4, ADDI 4, BEQ 3, J 3, JAL 3, SW 4, LW 5.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Opcode is sampled only in DECODE and MEMADR. The instruction register is stable from DECODE onward because we_ir=0 outside FETCH.
- Reset mid-instruction aborts it: no write enable pulses after rst rises, and the FSM restarts in FETCH after rst falls.

Test Plan:
1. rst=1, then release with mem_ready=1, opcode=000000 -> state 0 during reset with all enables 0; states 0,1,6,7,0; we_reg=1 and reg_dst=1 only in state 7; instr_done pulses once.
2. LW (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem2reg=1 and we_reg=1 only in state 4; total 7 cycles.
3. SW (101011) with mem_ready=0 for 1 cycle in MEMWR -> we_dm=1 for 2 consecutive cycles; instr_done only on the second; we_reg never asserted.
4. BEQ (000100) with zero=1, then repeated with zero=0 -> in BEQEX, pc_en=1 and pc_src=01 for zero=1; pc_en=0 for zero=0; 3 cycles each.
5. JAL (000011) then J (000010) -> JALEX asserts pc_en, jal and we_reg with pc_src=10; JEX asserts pc_en with jal=0 and we_reg=0.
6. opcode=111111 in DECODE, then rst pulsed during MEMRD of an LW -> illegal_op and instr_done pulse, then FETCH; reset forces state 0 immediately, and MEMWB and we_reg never occur.
